// File: rtl/video_timing_gen.sv
// ============================================================================
// Module      : video_timing_gen
// Description : Raster position counters with registered, coherent
//               sync / blanking / line-start / frame-start decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic        pixclk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] counterX,
  output logic [9:0]  counterY,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        line_start,
  output logic        frame_start
);

  localparam int          c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] c_x_last   = 11'(c_h_total - 1);
  localparam logic [9:0]  c_y_last   = 10'(c_v_total - 1);
  // 12-bit compare bounds so porch sums cannot overflow the counter widths
  localparam logic [11:0] c_h_act    = 12'(H_ACTIVE);
  localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] c_v_act    = 12'(V_ACTIVE);
  localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        r_ls;
  logic        r_fs;

  logic        w_x_wrap;
  logic [10:0] w_nx;
  logic [9:0]  w_ny;
  logic [11:0] w_nx12;
  logic [11:0] w_ny12;
  logic        w_de;
  logic        w_hs;
  logic        w_vs;
  logic        w_ls;
  logic        w_fs;

  // Decode from the next-state position so registered outputs line up with
  // the registered counters on the same cycle.
  always_comb begin
    w_x_wrap = (r_x == c_x_last);
    w_nx     = w_x_wrap ? 11'd0 : r_x + 11'd1;
    w_ny     = r_y;
    if (w_x_wrap) begin
      w_ny = (r_y == c_y_last) ? 10'd0 : r_y + 10'd1;
    end
    w_nx12 = {1'b0, w_nx};
    w_ny12 = {2'b0, w_ny};
    w_de   = (w_nx12 < c_h_act) && (w_ny12 < c_v_act);
    w_hs   = ((w_nx12 >= c_hs_start) && (w_nx12 < c_hs_end)) ? H_POL : ~H_POL;
    w_vs   = ((w_ny12 >= c_vs_start) && (w_ny12 < c_vs_end)) ? V_POL : ~V_POL;
    w_ls   = (w_nx == 11'd0);
    w_fs   = w_ls && (w_ny == 10'd0);
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= c_x_last;
      r_y  <= c_y_last;
      r_hs <= ~H_POL;
      r_vs <= ~V_POL;
      r_de <= 1'b0;
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end else if (en) begin
      r_x  <= w_nx;
      r_y  <= w_ny;
      r_hs <= w_hs;
      r_vs <= w_vs;
      r_de <= w_de;
      r_ls <= w_ls;
      r_fs <= w_fs;
    end
  end

  assign counterX    = r_x;
  assign counterY    = r_y;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign de          = r_de;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Directed self-checking bench for video_timing_gen (720p,
//               640x480 inverted-polarity and a tiny-raster instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

  logic pixclk = 1'b0;
  logic rst_n  = 1'b0;
  logic en     = 1'b0;

  always #5 pixclk = ~pixclk;

  logic [10:0] a_x, b_x, s_x;
  logic [9:0]  a_y, b_y, s_y;
  logic a_hs, a_vs, a_de, a_ls, a_fs;
  logic b_hs, b_vs, b_de, b_ls, b_fs;
  logic s_hs, s_vs, s_de, s_ls, s_fs;

  video_timing_gen dut_a (
    .pixclk(pixclk), .rst_n(rst_n), .en(en),
    .counterX(a_x), .counterY(a_y), .hsync(a_hs), .vsync(a_vs),
    .de(a_de), .line_start(a_ls), .frame_start(a_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_b (
    .pixclk(pixclk), .rst_n(rst_n), .en(en),
    .counterX(b_x), .counterY(b_y), .hsync(b_hs), .vsync(b_vs),
    .de(b_de), .line_start(b_ls), .frame_start(b_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_s (
    .pixclk(pixclk), .rst_n(rst_n), .en(en),
    .counterX(s_x), .counterY(s_y), .hsync(s_hs), .vsync(s_vs),
    .de(s_de), .line_start(s_ls), .frame_start(s_fs)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ax, ay, bx, by, sx, sy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {x, y, de, hsync, vsync, line_start, frame_start} at a position
  function automatic logic [25:0] model(input int x, input int y,
      input int ha, input int hf, input int hw, input int va, input int vf,
      input int vw, input bit hp, input bit vp);
    logic hs_on, vs_on;
    hs_on = (x >= ha + hf) && (x < ha + hf + hw);
    vs_on = (y >= va + vf) && (y < va + vf + vw);
    return {11'(x), 10'(y), (x < ha) && (y < va), hs_on ? hp : ~hp,
            vs_on ? vp : ~vp, x == 0, (x == 0) && (y == 0)};
  endfunction

  function automatic logic [25:0] exp_a();
    return model(ax, ay, 1280, 110, 40, 720, 5, 5, 1'b1, 1'b1);
  endfunction
  function automatic logic [25:0] exp_b();
    return model(bx, by, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
  endfunction
  function automatic logic [25:0] exp_s();
    return model(sx, sy, 8, 2, 3, 4, 1, 2, 1'b0, 1'b0);
  endfunction

  task automatic adv(inout int x, inout int y, input int ht, input int vt);
    if (x == ht - 1) begin
      x = 0;
      y = (y == vt - 1) ? 0 : y + 1;
    end else begin
      x = x + 1;
    end
  endtask

  task automatic model_reset();
    ax = 1649; ay = 749;
    bx = 799;  by = 524;
    sx = 15;   sy = 7;
  endtask

  task automatic step();
    @(posedge pixclk);
    #1;
    if (rst_n && en) begin
      adv(ax, ay, 1650, 750);
      adv(bx, by, 800, 525);
      adv(sx, sy, 16, 8);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_a"}, {a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs}, exp_a());
    check({tag, "_b"}, {b_x, b_y, b_de, b_hs, b_vs, b_ls, b_fs}, exp_b());
    check({tag, "_s"}, {s_x, s_y, s_de, s_hs, s_vs, s_ls, s_fs}, exp_s());
  endtask

  task automatic seek(input int tx, input int ty);
    int guard;
    guard = 0;
    while (!(ax == tx && ay == ty) && guard < 20000) begin
      step();
      check_all("seek");
      guard++;
    end
    if (guard >= 20000) check("seek_timeout", 0, 1);
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, hs_last, ls_cnt, bhs_low;
    int s_de_cnt, s_fs_cnt, s_ls_cnt, s_hs_low, s_vs_low;
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; bhs_low = 0;
    s_de_cnt = 0; s_fs_cnt = 0; s_ls_cnt = 0; s_hs_low = 0; s_vs_low = 0;

    model_reset();
    step();
    step();
    check("rst_x", a_x, 1649);
    check("rst_y", a_y, 749);
    check("rst_de", a_de, 0);
    check_all("rst");

    rst_n = 1'b1;
    en    = 1'b1;
    step();
    check("first_xy", {a_x, a_y}, 0);
    check("first_de", a_de, 1);
    check("first_ls", a_ls, 1);
    check("first_fs", a_fs, 1);
    check("first_syncs", {a_hs, a_vs}, 2'b00);

    for (int i = 0; i <= 1650; i++) begin
      check_all("run");
      if (i < 1650) begin
        de_cnt += a_de;
        ls_cnt += a_ls;
        if (a_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(a_x);
          hs_last = int'(a_x);
        end
      end
      if (i < 1600 && !b_hs) bhs_low++;
      if (i < 128) begin
        s_de_cnt += s_de;
        s_fs_cnt += s_fs;
        s_ls_cnt += s_ls;
        if (!s_hs) s_hs_low++;
        if (!s_vs) s_vs_low++;
      end
      if (i == 128) check("s_frame_wrap", {s_x, s_y}, 0);
      if (i == 799) check("b_last_x", b_x, 799);
      if (i == 800) check("b_wrap_x", b_x, 0);
      if (i == 1650) check("line_wrap", {a_x, a_y}, {11'd0, 10'd1});
      step();
    end
    check("line_de_cnt", de_cnt, 1280);
    check("line_hs_cnt", hs_cnt, 40);
    check("line_hs_first", hs_first, 1390);
    check("line_hs_last", hs_last, 1429);
    check("line_ls_cnt", ls_cnt, 1);
    check("b_hs_low_cnt", bhs_low, 192);
    check("s_de_cnt", s_de_cnt, 32);
    check("s_fs_cnt", s_fs_cnt, 1);
    check("s_ls_cnt", s_ls_cnt, 8);
    check("s_hs_low_cnt", s_hs_low, 24);
    check("s_vs_low_cnt", s_vs_low, 32);

    seek(500, 3);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_xy", {a_x, a_y}, {11'd500, 10'd3});
      check("hold_de", a_de, 1);
      check_all("hold");
    end
    en = 1'b1;
    step();
    check("resume_x", a_x, 501);
    check_all("resume");

    seek(700, 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_xy", {a_x, a_y}, {11'd1649, 10'd749});
    check("async_rst_de", a_de, 0);
    check_all("async_rst");
    step();
    rst_n = 1'b1;
    step();
    check("rerun_first", {a_x, a_y, a_de, a_ls, a_fs}, {11'd0, 10'd0, 3'b111});
    check_all("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
